nts_tx_buffer: RTL and testbench

Engine-side transmit packet buffer: the write end of the engine→extractor TX interface. It accepts one response packet from the NTS engine's packet builder as 64-bit words, then presents it to the extractor through the packet-available / rd_start / rd_valid / packet_read handshake. It holds a single packet of up to 2^ADDR_WIDTH words in one RAM bank and is instantiated inside each NTS engine.

---
 rtl/nts_tx_buffer_if.sv | 38 +++
 rtl/nts_tx_buffer.sv | 152 +++++++++++++++
 tb/tb_nts_tx_buffer.sv | 271 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/nts_tx_buffer_if.sv
// Engine-to-extractor TX buffer bus: the packet-builder write side and the
// extractor dispatch/read side, grouped for the nts_tx_buffer port.
interface nts_tx_buffer_if #(
    parameter int unsigned DATA_WIDTH = 64
);
    logic                  write_en;
    logic [DATA_WIDTH-1:0] write_data;
    logic                  write_last;
    logic [3:0]            write_bytes;
    logic                  write_discard;
    logic                  write_ready;
    logic                  overflow;
    logic                  dispatch_tx_packet_available;
    logic                  dispatch_tx_packet_read;
    logic                  dispatch_tx_fifo_empty;
    logic                  dispatch_tx_fifo_rd_start;
    logic                  dispatch_tx_fifo_rd_valid;
    logic [DATA_WIDTH-1:0] dispatch_tx_fifo_rd_data;
    logic [3:0]            dispatch_tx_bytes_last_word;

    // Buffer side
    modport slave (
        input  write_en, write_data, write_last, write_bytes, write_discard,
        input  dispatch_tx_packet_read, dispatch_tx_fifo_rd_start,
        output write_ready, overflow, dispatch_tx_packet_available,
        output dispatch_tx_fifo_empty, dispatch_tx_fifo_rd_valid,
        output dispatch_tx_fifo_rd_data, dispatch_tx_bytes_last_word
    );

    // Packet builder / extractor side
    modport master (
        output write_en, write_data, write_last, write_bytes, write_discard,
        output dispatch_tx_packet_read, dispatch_tx_fifo_rd_start,
        input  write_ready, overflow, dispatch_tx_packet_available,
        input  dispatch_tx_fifo_empty, dispatch_tx_fifo_rd_valid,
        input  dispatch_tx_fifo_rd_data, dispatch_tx_bytes_last_word
    );
endinterface

// File: rtl/nts_tx_buffer.sv
// Single-packet TX buffer between the NTS engine packet builder and the extractor.
// Optional NTS_TX_BUFFER_ZERO_PAD_EN zeroes unused bytes of the final streamed word.
module nts_tx_buffer #(
    parameter int unsigned ADDR_WIDTH     = 8,
    parameter int unsigned MAC_DATA_WIDTH = 64
) (
    input logic             i_clk,
    input logic             i_areset,
    nts_tx_buffer_if.slave  bus
);
    localparam int unsigned DEPTH  = 2 ** ADDR_WIDTH;
    localparam int unsigned PW     = ADDR_WIDTH + 1;
    localparam int unsigned NBYTES = MAC_DATA_WIDTH / 8;
    localparam logic [PW-1:0] FULL = PW'(DEPTH);
`ifdef NTS_TX_BUFFER_ZERO_PAD_EN
    localparam bit ZERO_PAD = 1'b1;
`else
    localparam bit ZERO_PAD = 1'b0;
`endif

    typedef enum logic [2:0] {
        S_EMPTY, S_FILLING, S_AVAILABLE, S_STREAMING, S_DRAINED
    } state_t;

    state_t state, state_d;

    logic [MAC_DATA_WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]             wr_ptr, rd_ptr, count;
    logic                      bad;
    logic [3:0]                bytes_last;
    logic [MAC_DATA_WIDTH-1:0] rd_data_q, pad_mask;

    logic write_ready_q, overflow_q, available_q, fifo_empty_q, rd_valid_q;
    logic write_ready_d, overflow_d, available_d, fifo_empty_d, rd_valid_d;

    logic filling_phase, discard, wr_fire, ovf_hit, commit, drop, issue, last_issue;

    // Handshake decode shared by the FSM and the datapath
    always_comb begin
        filling_phase = (state == S_EMPTY) || (state == S_FILLING);
        discard       = filling_phase && bus.write_discard;
        wr_fire       = filling_phase && bus.write_en && !bus.write_discard;
        ovf_hit       = bad || (wr_ptr == FULL);
        commit        = wr_fire && bus.write_last && !ovf_hit;
        drop          = wr_fire && bus.write_last && ovf_hit;
        issue         = (state == S_STREAMING) && (rd_ptr != count)
                        && !bus.dispatch_tx_packet_read;
        last_issue    = issue && (rd_ptr == count - PW'(1));
    end

    // State register and registered outputs
    always_ff @(posedge i_clk or posedge i_areset) begin
        if (i_areset) begin
            state         <= S_EMPTY;
            write_ready_q <= 1'b1;
            overflow_q    <= 1'b0;
            available_q   <= 1'b0;
            fifo_empty_q  <= 1'b1;
            rd_valid_q    <= 1'b0;
        end else begin
            state         <= state_d;
            write_ready_q <= write_ready_d;
            overflow_q    <= overflow_d;
            available_q   <= available_d;
            fifo_empty_q  <= fifo_empty_d;
            rd_valid_q    <= rd_valid_d;
        end
    end

    // Next-state logic; packet_read takes priority over rd_start
    always_comb begin
        state_d = state;
        case (state)
            S_EMPTY, S_FILLING: begin
                if (discard)     state_d = S_EMPTY;
                else if (commit) state_d = S_AVAILABLE;
                else if (drop)   state_d = S_EMPTY;
                else if (wr_fire) state_d = S_FILLING;
            end
            S_AVAILABLE: begin
                if (bus.dispatch_tx_packet_read)        state_d = S_EMPTY;
                else if (bus.dispatch_tx_fifo_rd_start) state_d = S_STREAMING;
            end
            S_STREAMING: begin
                if (bus.dispatch_tx_packet_read) state_d = S_EMPTY;
                else if (last_issue)             state_d = S_DRAINED;
            end
            S_DRAINED: begin
                if (bus.dispatch_tx_packet_read) state_d = S_EMPTY;
            end
            default: state_d = S_EMPTY;
        endcase
    end

    // Output decode from the upcoming state so outputs line up with it
    always_comb begin
        write_ready_d = (state_d == S_EMPTY) || (state_d == S_FILLING);
        available_d   = (state_d == S_AVAILABLE) || (state_d == S_STREAMING)
                        || (state_d == S_DRAINED);
        fifo_empty_d  = !((state_d == S_AVAILABLE) || (state_d == S_STREAMING));
        rd_valid_d    = issue;
        overflow_d    = drop;
    end

    always_comb begin
        pad_mask = '1;
        if (ZERO_PAD && last_issue) begin
            for (int unsigned b = 0; b < NBYTES; b++) begin
                if (b >= 32'(bytes_last)) pad_mask[MAC_DATA_WIDTH-1-8*b -: 8] = 8'h00;
            end
        end
    end

    // Packet RAM; words beyond capacity are dropped
    always_ff @(posedge i_clk) begin
        if (wr_fire && !wr_ptr[ADDR_WIDTH]) mem[wr_ptr[ADDR_WIDTH-1:0]] <= bus.write_data;
    end

    always_ff @(posedge i_clk or posedge i_areset) begin
        if (i_areset) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            bad        <= 1'b0;
            bytes_last <= 4'd0;
            rd_data_q  <= '0;
        end else begin
            if (state_d == S_EMPTY) begin
                wr_ptr <= '0;
                bad    <= 1'b0;
            end else if (wr_fire && !bus.write_last) begin
                if (wr_ptr == FULL) bad <= 1'b1;
                else                wr_ptr <= wr_ptr + PW'(1);
            end
            if (commit) begin
                count      <= wr_ptr + PW'(1);
                bytes_last <= (bus.write_bytes == 4'd0) ? 4'(NBYTES) : bus.write_bytes;
            end
            if (state == S_AVAILABLE) rd_ptr <= '0;
            else if (issue)           rd_ptr <= rd_ptr + PW'(1);
            if (issue) rd_data_q <= mem[rd_ptr[ADDR_WIDTH-1:0]] & pad_mask;
        end
    end

    assign bus.write_ready                  = write_ready_q;
    assign bus.overflow                     = overflow_q;
    assign bus.dispatch_tx_packet_available = available_q;
    assign bus.dispatch_tx_fifo_empty       = fifo_empty_q;
    assign bus.dispatch_tx_fifo_rd_valid    = rd_valid_q;
    assign bus.dispatch_tx_fifo_rd_data     = rd_data_q;
    assign bus.dispatch_tx_bytes_last_word  = bytes_last;
endmodule

// File: tb/tb_nts_tx_buffer.sv
// Self-checking bench for nts_tx_buffer: a 256-word instance for streaming and
// a 16-word instance sharing the same inputs for the capacity boundary.
module tb_nts_tx_buffer;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    nts_tx_buffer_if bus_a ();
    nts_tx_buffer_if bus_b ();

    assign bus_b.write_en                  = bus_a.write_en;
    assign bus_b.write_data                = bus_a.write_data;
    assign bus_b.write_last                = bus_a.write_last;
    assign bus_b.write_bytes               = bus_a.write_bytes;
    assign bus_b.write_discard             = bus_a.write_discard;
    assign bus_b.dispatch_tx_packet_read   = bus_a.dispatch_tx_packet_read;
    assign bus_b.dispatch_tx_fifo_rd_start = bus_a.dispatch_tx_fifo_rd_start;

    nts_tx_buffer #(.ADDR_WIDTH(8), .MAC_DATA_WIDTH(64)) dut_a (
        .i_clk(clk), .i_areset(rst), .bus(bus_a));
    nts_tx_buffer #(.ADDR_WIDTH(4), .MAC_DATA_WIDTH(64)) dut_b (
        .i_clk(clk), .i_areset(rst), .bus(bus_b));

    typedef struct {
        int         n;
        logic [3:0] bytes;
        int         kind;       // 0 ramp, 1 random, 2 random with all-ones last, 3 DEADBEEF
        logic [3:0] exp_bytes;
    } vec_t;

    vec_t        vecs [6];
    logic [63:0] exp_q [$];
    int          checks = 0;
    int          errors = 0;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [63:0] pad(input logic [63:0] w, input int nb);
        logic [63:0] r;
        r = w;
        for (int b = 0; b < 8; b++) begin
            if (b >= nb) begin
`ifdef NTS_TX_BUFFER_ZERO_PAD_EN
                r[63-8*b -: 8] = 8'h00;
`endif
            end
        end
        return r;
    endfunction

    task automatic write_pkt(input int n, input logic [3:0] bytes, input int kind,
                             input bit push, input bit with_last);
        logic [63:0] w;
        bit          last;
        int          eb;
        eb = (bytes == 4'd0) ? 8 : int'(bytes);
        for (int i = 0; i < n; i++) begin
            last = with_last && (i == n - 1);
            case (kind)
                0:       w = 64'(i + 1) * 64'h0101;
                2:       w = last ? '1 : {$urandom(), $urandom()};
                3:       w = 64'hDEADBEEF_00000000;
                default: w = {$urandom(), $urandom()};
            endcase
            bus_a.write_en    = 1'b1;
            bus_a.write_data  = w;
            bus_a.write_last  = last;
            bus_a.write_bytes = last ? bytes : 4'd0;
            if (push) exp_q.push_back(last ? pad(w, eb) : w);
            tick();
        end
        bus_a.write_en    = 1'b0;
        bus_a.write_last  = 1'b0;
        bus_a.write_bytes = 4'd0;
    endtask

    task automatic stream(input int n, input string tag);
        bus_a.dispatch_tx_fifo_rd_start = 1'b1;
        tick();
        bus_a.dispatch_tx_fifo_rd_start = 1'b0;
        check({tag, "/lat"}, bus_a.dispatch_tx_fifo_rd_valid, 0);
        for (int k = 0; k < n; k++) begin
            tick();
            check({tag, "/valid"}, bus_a.dispatch_tx_fifo_rd_valid, 1);
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL %s/data: got %h expected no word", tag,
                         bus_a.dispatch_tx_fifo_rd_data);
            end else begin
                logic [63:0] e;
                e = exp_q.pop_front();
                if (bus_a.dispatch_tx_fifo_rd_data !== e) begin
                    errors++;
                    $display("FAIL %s/data[%0d]: got %h expected %h", tag, k,
                             bus_a.dispatch_tx_fifo_rd_data, e);
                end
            end
            check({tag, "/empty"}, bus_a.dispatch_tx_fifo_empty, (k == n - 1) ? 1 : 0);
        end
        tick();
        check({tag, "/valid_end"}, bus_a.dispatch_tx_fifo_rd_valid, 0);
        check({tag, "/empty_end"}, bus_a.dispatch_tx_fifo_empty, 1);
        check({tag, "/avail_drained"}, bus_a.dispatch_tx_packet_available, 1);
    endtask

    task automatic pkt_read(input string tag);
        bus_a.dispatch_tx_packet_read = 1'b1;
        tick();
        bus_a.dispatch_tx_packet_read = 1'b0;
        check({tag, "/avail_rel"}, bus_a.dispatch_tx_packet_available, 0);
        check({tag, "/ready_rel"}, bus_a.write_ready, 1);
        check({tag, "/empty_rel"}, bus_a.dispatch_tx_fifo_empty, 1);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "/ready"}, bus_a.write_ready, 1);
        check({tag, "/empty"}, bus_a.dispatch_tx_fifo_empty, 1);
        check({tag, "/avail"}, bus_a.dispatch_tx_packet_available, 0);
        check({tag, "/valid"}, bus_a.dispatch_tx_fifo_rd_valid, 0);
        check({tag, "/data"}, bus_a.dispatch_tx_fifo_rd_data, 64'h0);
        check({tag, "/bytes"}, bus_a.dispatch_tx_bytes_last_word, 4'd0);
        check({tag, "/ovf"}, bus_a.overflow, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        bus_a.write_en = 1'b0;
        bus_a.write_data = '0;
        bus_a.write_last = 1'b0;
        bus_a.write_bytes = 4'd0;
        bus_a.write_discard = 1'b0;
        bus_a.dispatch_tx_packet_read = 1'b0;
        bus_a.dispatch_tx_fifo_rd_start = 1'b0;

        vecs[0] = '{n: 10, bytes: 4'd4, kind: 0, exp_bytes: 4'd4};
        vecs[1] = '{n: 1,  bytes: 4'd0, kind: 3, exp_bytes: 4'd8};
        vecs[2] = '{n: 3,  bytes: 4'd1, kind: 1, exp_bytes: 4'd1};
        vecs[3] = '{n: 7,  bytes: 4'd8, kind: 1, exp_bytes: 4'd8};
        vecs[4] = '{n: 1,  bytes: 4'd3, kind: 2, exp_bytes: 4'd3};
        vecs[5] = '{n: 20, bytes: 4'd3, kind: 2, exp_bytes: 4'd3};

        tick();
        tick();
        rst = 1'b0;
        check_reset_outputs("reset");
        check("reset/b_ready", bus_b.write_ready, 1);
        tick();

        // Table: commit, stream, release; next packet starts the cycle after release
        for (int v = 0; v < 6; v++) begin
            string tag;
            tag = $sformatf("vec%0d", v);
            write_pkt(vecs[v].n, vecs[v].bytes, vecs[v].kind, 1'b1, 1'b1);
            check({tag, "/avail"}, bus_a.dispatch_tx_packet_available, 1);
            check({tag, "/ready"}, bus_a.write_ready, 0);
            check({tag, "/empty_avail"}, bus_a.dispatch_tx_fifo_empty, 0);
            check({tag, "/bytes"}, bus_a.dispatch_tx_bytes_last_word, vecs[v].exp_bytes);
            stream(vecs[v].n, tag);
            pkt_read(tag);
        end

        // Discard with a concurrent write, then a clean 3-word packet
        write_pkt(5, 4'd0, 1, 1'b0, 1'b0);
        bus_a.write_en = 1'b1;
        bus_a.write_discard = 1'b1;
        bus_a.write_data = 64'h1234_5678_9ABC_DEF0;
        tick();
        bus_a.write_en = 1'b0;
        bus_a.write_discard = 1'b0;
        check("discard/ready", bus_a.write_ready, 1);
        check("discard/avail", bus_a.dispatch_tx_packet_available, 0);
        write_pkt(3, 4'd2, 1, 1'b1, 1'b1);
        check("discard/avail2", bus_a.dispatch_tx_packet_available, 1);
        stream(3, "discard");
        check("discard/queue", 64'(exp_q.size()), 64'd0);
        pkt_read("discard");

        // rd_start and packet_read together: release wins
        write_pkt(2, 4'd0, 1, 1'b0, 1'b1);
        bus_a.dispatch_tx_fifo_rd_start = 1'b1;
        bus_a.dispatch_tx_packet_read = 1'b1;
        tick();
        bus_a.dispatch_tx_fifo_rd_start = 1'b0;
        bus_a.dispatch_tx_packet_read = 1'b0;
        check("both/avail", bus_a.dispatch_tx_packet_available, 0);
        check("both/ready", bus_a.write_ready, 1);
        tick();
        check("both/valid", bus_a.dispatch_tx_fifo_rd_valid, 0);
        bus_a.dispatch_tx_fifo_rd_start = 1'b1;
        tick();
        bus_a.dispatch_tx_fifo_rd_start = 1'b0;
        tick();
        check("idle_start/valid", bus_a.dispatch_tx_fifo_rd_valid, 0);
        check("idle_start/empty", bus_a.dispatch_tx_fifo_empty, 1);

        // Abort a 20-word stream 3 cycles after rd_start
        write_pkt(20, 4'd5, 1, 1'b1, 1'b1);
        bus_a.dispatch_tx_fifo_rd_start = 1'b1;
        tick();
        bus_a.dispatch_tx_fifo_rd_start = 1'b0;
        tick();
        check("abort/valid0", bus_a.dispatch_tx_fifo_rd_valid, 1);
        check("abort/data0", bus_a.dispatch_tx_fifo_rd_data, exp_q.pop_front());
        tick();
        check("abort/valid1", bus_a.dispatch_tx_fifo_rd_valid, 1);
        check("abort/data1", bus_a.dispatch_tx_fifo_rd_data, exp_q.pop_front());
        bus_a.dispatch_tx_packet_read = 1'b1;
        tick();
        bus_a.dispatch_tx_packet_read = 1'b0;
        check("abort/valid_off", bus_a.dispatch_tx_fifo_rd_valid, 0);
        check("abort/ready", bus_a.write_ready, 1);
        check("abort/avail", bus_a.dispatch_tx_packet_available, 0);
        exp_q.delete();

        // Asynchronous reset mid-stream
        write_pkt(20, 4'd5, 1, 1'b0, 1'b1);
        bus_a.dispatch_tx_fifo_rd_start = 1'b1;
        tick();
        bus_a.dispatch_tx_fifo_rd_start = 1'b0;
        tick();
        tick();
        rst = 1'b1;
        #1;
        check_reset_outputs("midreset");
        tick();
        rst = 1'b0;
        tick();
        check_reset_outputs("postreset");

        // 17 words then last on the 16-deep instance: dropped with overflow pulse
        write_pkt(18, 4'd2, 1, 1'b0, 1'b1);
        check("ovf/b_pulse", bus_b.overflow, 1);
        check("ovf/b_avail", bus_b.dispatch_tx_packet_available, 0);
        check("ovf/b_ready", bus_b.write_ready, 1);
        check("ovf/a_pulse", bus_a.overflow, 0);
        check("ovf/a_avail", bus_a.dispatch_tx_packet_available, 1);
        tick();
        check("ovf/b_pulse_end", bus_b.overflow, 0);
        check("ovf/b_avail_end", bus_b.dispatch_tx_packet_available, 0);
        pkt_read("ovf");

        // Exactly full on the 16-deep instance is a legal packet
        write_pkt(16, 4'd6, 1, 1'b1, 1'b1);
        check("full/b_avail", bus_b.dispatch_tx_packet_available, 1);
        check("full/b_ovf", bus_b.overflow, 0);
        check("full/b_bytes", bus_b.dispatch_tx_bytes_last_word, 4'd6);
        stream(16, "full");
        pkt_read("full");
        check("full/b_ready", bus_b.write_ready, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
